// File: rtl/stroke_pacer_if.sv
// Config handshake bundle for stroke_pacer: valid/ready offer of drive length and
// recovery:drive ratio. The master is the config source, the slave the pacer.
interface stroke_pacer_if #(
  parameter int DRIVE_W = 16,
  parameter int RATIO_W = 8
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [DRIVE_W-1:0] cfg_drive_len;
  logic [RATIO_W-1:0] cfg_ratio;

  modport master (output cfg_valid, output cfg_drive_len, output cfg_ratio, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_drive_len, input cfg_ratio, output cfg_ready);
endinterface

// File: rtl/stroke_pacer.sv
// Paced rowing-stroke pulse generator with a one-deep config shadow register.
// Optional STROKE_PACER_COUNT_EN builds the completed-stroke counter; otherwise stroke_count is 0.
module stroke_pacer #(
  parameter int DRIVE_W = 16,
  parameter int RATIO_W = 8
) (
  input  logic            count_clock,
  input  logic            reset_n,
  input  logic            enable,
  stroke_pacer_if.slave   cfg,
  output logic            start_drive,
  output logic            start_recovery,
  output logic            busy,
  output logic            phase,
  output logic [15:0]     stroke_count
);
  localparam int CNT_W = DRIVE_W + RATIO_W;

  typedef enum logic [1:0] {IDLE, DRIVE, RECOVERY} state_t;

  state_t             state_q, state_d;
  logic               sh_full_q, sh_full_d;
  logic               act_valid_q, act_valid_d;
  logic               start_drive_q, start_drive_d;
  logic               start_recovery_q, start_recovery_d;
  logic               busy_q, busy_d;
  logic               phase_q, phase_d;
  logic [DRIVE_W-1:0] sh_drive_q, sh_drive_d;
  logic [CNT_W-1:0]   sh_rec_q, sh_rec_d;
  logic [DRIVE_W-1:0] act_drive_q, act_drive_d;
  logic [CNT_W-1:0]   act_rec_q, act_rec_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               go_drive;
  logic               stroke_done;

  function automatic logic [DRIVE_W-1:0] clamp_drive(input logic [DRIVE_W-1:0] d);
    return (d == '0) ? DRIVE_W'(1) : d;
  endfunction

  // Full-width product so long drives at high ratios never truncate.
  function automatic logic [CNT_W-1:0] clamp_rec(input logic [DRIVE_W-1:0] d,
                                                 input logic [RATIO_W-1:0] r);
    logic [CNT_W-1:0] p;
    p = CNT_W'(d) * CNT_W'(r);
    return (p == '0) ? CNT_W'(1) : p;
  endfunction

  assign accept        = cfg.cfg_valid & ~sh_full_q;
  assign cfg.cfg_ready = ~sh_full_q;

  always_comb begin
    state_d          = state_q;
    sh_full_d        = sh_full_q;
    act_valid_d      = act_valid_q;
    sh_drive_d       = sh_drive_q;
    sh_rec_d         = sh_rec_q;
    act_drive_d      = act_drive_q;
    act_rec_d        = act_rec_q;
    cnt_d            = cnt_q;
    start_drive_d    = 1'b0;
    start_recovery_d = 1'b0;
    go_drive         = 1'b0;
    stroke_done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable && (act_valid_q || sh_full_q)) go_drive = 1'b1;
      end
      DRIVE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d          = RECOVERY;
          cnt_d            = act_rec_q;
          start_recovery_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RECOVERY: begin
        if (cnt_q == CNT_W'(1)) begin
          stroke_done = 1'b1;
          if (enable) go_drive = 1'b1;
          else        state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A pending shadow is promoted only at a stroke boundary, never mid-stroke.
    if (go_drive) begin
      state_d       = DRIVE;
      start_drive_d = 1'b1;
      if (sh_full_q) begin
        act_drive_d = sh_drive_q;
        act_rec_d   = sh_rec_q;
        act_valid_d = 1'b1;
        sh_full_d   = 1'b0;
        cnt_d       = {{RATIO_W{1'b0}}, sh_drive_q};
      end else begin
        cnt_d = {{RATIO_W{1'b0}}, act_drive_q};
      end
    end

    if (accept) begin
      sh_drive_d = clamp_drive(cfg.cfg_drive_len);
      sh_rec_d   = clamp_rec(clamp_drive(cfg.cfg_drive_len), cfg.cfg_ratio);
      sh_full_d  = 1'b1;
    end

    busy_d  = (state_d != IDLE);
    phase_d = (state_d == RECOVERY);
  end

  always_ff @(posedge count_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= IDLE;
      sh_full_q        <= 1'b0;
      act_valid_q      <= 1'b0;
      start_drive_q    <= 1'b0;
      start_recovery_q <= 1'b0;
      busy_q           <= 1'b0;
      phase_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      sh_full_q        <= sh_full_d;
      act_valid_q      <= act_valid_d;
      start_drive_q    <= start_drive_d;
      start_recovery_q <= start_recovery_d;
      busy_q           <= busy_d;
      phase_q          <= phase_d;
    end
  end

  // Datapath registers are qualified by sh_full/act_valid, so they need no reset.
  always_ff @(posedge count_clock) begin
    sh_drive_q  <= sh_drive_d;
    sh_rec_q    <= sh_rec_d;
    act_drive_q <= act_drive_d;
    act_rec_q   <= act_rec_d;
    cnt_q       <= cnt_d;
  end

`ifdef STROKE_PACER_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (stroke_done) count_d = count_q + 16'd1;
  end

  always_ff @(posedge count_clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

  assign stroke_count = count_q;
`else
  logic unused_stroke_done;
  assign unused_stroke_done = stroke_done;
  assign stroke_count       = '0;
`endif

  assign start_drive    = start_drive_q;
  assign start_recovery = start_recovery_q;
  assign busy           = busy_q;
  assign phase          = phase_q;
endmodule

// File: tb/tb_stroke_pacer.sv
// Bench for stroke_pacer: table of config/period vectors, directed corner sequences,
// and random multi-stroke episodes checked against a stroke-schedule model.
module tb_stroke_pacer;
  localparam int DW = 16;
  localparam int RW = 8;
`ifdef STROKE_PACER_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        start_drive, start_recovery, busy, phase;
  logic [15:0] stroke_count;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int base = 0;

  typedef struct {
    int drive;
    int ratio;
    int exp_d;
    int exp_r;
  } vec_t;
  vec_t vecs[9];

  stroke_pacer_if #(.DRIVE_W(DW), .RATIO_W(RW)) cfg_if ();

  stroke_pacer #(.DRIVE_W(DW), .RATIO_W(RW)) dut (
    .count_clock   (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .cfg           (cfg_if),
    .start_drive   (start_drive),
    .start_recovery(start_recovery),
    .busy          (busy),
    .phase         (phase),
    .stroke_count  (stroke_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int eff_d(input int d);
    return (d == 0) ? 1 : d;
  endfunction

  function automatic int eff_r(input int d, input int r);
    int p;
    p = eff_d(d) * r;
    return (p == 0) ? 1 : p;
  endfunction

  function automatic int exp_count(input int n);
    return COUNT_EN ? (n % 65536) : 0;
  endfunction

  task automatic set_cfg(input bit v, input int d, input int r);
    cfg_if.cfg_valid     = v;
    cfg_if.cfg_drive_len = DW'(d);
    cfg_if.cfg_ratio     = RW'(r);
  endtask

  // which: 0 start_drive, 1 start_recovery, 2 busy low
  task automatic wait_for(input int which, input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if ((which == 0 && start_drive) || (which == 1 && start_recovery) ||
          (which == 2 && !busy)) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      checks++;
      failures++;
      $display("FAIL timeout_wait%0d cyc=%0d actual=no_event required=event_within_%0d", which, cyc, limit);
    end
  endtask

  // Starts idle with enable low. Config A is offered, enable raised after the accept,
  // optional config B offered during stroke 0, enable dropped in the last of k strokes.
  task automatic run_episode(input int da, input int ra, input bit use_b, input int db,
                             input int rb, input int k, input int mid_sel, input int drop_sel);
    int S[6];
    int D[5];
    int R[5];
    int n, c0, c_mid, c_drop, c_end, done;
    bit sd, sr, bz, ph, rdy;
    c0 = cyc;
    n  = c0 + 1;
    S[0] = n + 1;
    for (int j = 0; j < k; j++) begin
      D[j]   = (j > 0 && use_b) ? eff_d(db) : eff_d(da);
      R[j]   = (j > 0 && use_b) ? eff_r(db, rb) : eff_r(da, ra);
      S[j+1] = S[j] + D[j] + R[j];
    end
    c_mid  = S[0] + (mid_sel % (D[0] + R[0] - 1));
    c_drop = S[k-1] + (drop_sel % (D[k-1] + R[k-1]));
    c_end  = S[k] + 2;
    set_cfg(1'b1, da, ra);
    enable = 1'b0;
    for (int c = c0 + 1; c <= c_end; c++) begin
      @(negedge clk);
      sd = 0; sr = 0; ph = 0; done = 0;
      for (int j = 0; j < k; j++) begin
        if (c == S[j]) sd = 1;
        if (c == S[j] + D[j]) sr = 1;
        if (c >= S[j] + D[j] && c < S[j+1]) ph = 1;
        if (c >= S[j+1]) done++;
      end
      bz  = (c >= S[0]) && (c < S[k]);
      rdy = !((c == n) || (use_b && c > c_mid && c < S[1]));
      chk("ep_start_drive", int'(start_drive), int'(sd));
      chk("ep_start_recovery", int'(start_recovery), int'(sr));
      chk("ep_busy", int'(busy), int'(bz));
      chk("ep_phase", int'(phase), int'(ph));
      chk("ep_cfg_ready", int'(cfg_if.cfg_ready), int'(rdy));
      chk("ep_stroke_count", int'(stroke_count), exp_count(base + done));
      if (c == n) begin
        set_cfg(1'b0, 0, 0);
        enable = 1'b1;
      end
      if (use_b && c == c_mid) set_cfg(1'b1, db, rb);
      if (use_b && c == c_mid + 1) set_cfg(1'b0, 0, 0);
      if (c == c_drop) enable = 1'b0;
    end
    base += k;
  endtask

  initial begin
    int t0, t1, t2, seen;
    int da, ra, db, rb, k;
    bit ub;

    vecs[0] = '{4, 2, 4, 8};
    vecs[1] = '{3, 1, 3, 3};
    vecs[2] = '{0, 0, 1, 1};
    vecs[3] = '{1, 0, 1, 1};
    vecs[4] = '{0, 3, 1, 3};
    vecs[5] = '{5, 0, 5, 1};
    vecs[6] = '{2, 3, 2, 6};
    vecs[7] = '{20, 4, 20, 80};
    vecs[8] = '{1, 255, 1, 255};

    reset_n = 1'b0;
    enable  = 1'b0;
    set_cfg(1'b0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_start_drive", int'(start_drive), 0);
    chk("rst_start_recovery", int'(start_recovery), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_phase", int'(phase), 0);
    chk("rst_cfg_ready", int'(cfg_if.cfg_ready), 1);
    chk("rst_stroke_count", int'(stroke_count), 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", int'(busy), 0);

    foreach (vecs[i]) begin
      set_cfg(1'b1, vecs[i].drive, vecs[i].ratio);
      enable = 1'b0;
      @(negedge clk);
      set_cfg(1'b0, 0, 0);
      enable = 1'b1;
      wait_for(0, 5, t0);
      wait_for(1, 200, t1);
      enable = 1'b0;
      wait_for(2, 500, t2);
      chk("vec_drive_len", t1 - t0, vecs[i].exp_d);
      chk("vec_rec_len", t2 - t1, vecs[i].exp_r);
      seen = 0;
      repeat (3) begin
        @(negedge clk);
        if (start_drive) seen++;
      end
      chk("vec_no_restart", seen, 0);
      base++;
    end

    run_episode(4, 2, 1'b0, 0, 0, 3, 0, 5);
    run_episode(4, 2, 1'b1, 3, 1, 2, 1, 0);
    run_episode(4, 2, 1'b0, 0, 0, 1, 0, 1);
    run_episode(0, 0, 1'b0, 0, 0, 4, 0, 1);
    run_episode(2, 1, 1'b0, 0, 0, 5, 0, 0);

    for (int e = 0; e < 25; e++) begin
      da = $urandom_range(0, 6);
      ra = $urandom_range(0, 3);
      db = $urandom_range(0, 6);
      rb = $urandom_range(0, 3);
      ub = 1'($urandom_range(0, 1));
      k  = ub ? $urandom_range(2, 4) : $urandom_range(1, 4);
      run_episode(da, ra, ub, db, rb, k, $urandom_range(0, 63), $urandom_range(0, 63));
    end

    // Reset mid-recovery after three completed strokes.
    set_cfg(1'b1, 4, 2);
    @(negedge clk);
    set_cfg(1'b0, 0, 0);
    enable = 1'b1;
    for (int i = 0; i < 4; i++) wait_for(0, 30, t0);
    wait_for(1, 10, t1);
    repeat (2) @(negedge clk);
    chk("pre_rst_phase", int'(phase), 1);
    chk("pre_rst_count", int'(stroke_count), exp_count(base + 3));
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_start_drive", int'(start_drive), 0);
    chk("mid_rst_start_recovery", int'(start_recovery), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_phase", int'(phase), 0);
    chk("mid_rst_cfg_ready", int'(cfg_if.cfg_ready), 1);
    chk("mid_rst_count", int'(stroke_count), 0);
    base = 0;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (start_drive || busy) seen++;
    end
    chk("no_start_without_cfg", seen, 0);
    set_cfg(1'b1, 2, 1);
    @(negedge clk);
    chk("en_hi_cfg_ready_n", int'(cfg_if.cfg_ready), 0);
    chk("en_hi_start_drive_n", int'(start_drive), 0);
    set_cfg(1'b0, 0, 0);
    @(negedge clk);
    chk("en_hi_start_drive_n1", int'(start_drive), 1);
    chk("en_hi_cfg_ready_n1", int'(cfg_if.cfg_ready), 1);
    enable = 1'b0;
    wait_for(2, 20, t2);
    base = 1;
    chk("final_stroke_count", int'(stroke_count), exp_count(base));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
